// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-wide data RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended (big-endian).
module dmem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i
);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        seen_low_q, seen_low_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic        ce_q, ce_d;
  logic        we_q, we_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rwdata_q, rwdata_d;

  function automatic logic is_misaligned(input op_t op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input op_t op);
    return !(op inside {OP_SB, OP_SH, OP_SW});
  endfunction

  // Lane 0 is the most significant byte, so the shift is (3-off)*8 = {~off,3'b0}.
  function automatic logic [31:0] load_fmt(input op_t op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {~off, 3'b000});
    h = 16'(w >> {~off[1], 4'b0000});
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input op_t op, input logic [1:0] off,
                                              input logic [15:0] wd, input logic [31:0] w);
    logic [31:0] mask;
    logic [31:0] ins;
    if (op == OP_SB) begin
      mask = 32'h0000_00FF << {~off, 3'b000};
      ins  = {24'h000000, wd[7:0]} << {~off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {~off[1], 4'b0000};
      ins  = {16'h0000, wd} << {~off[1], 4'b0000};
    end
    return (w & ~mask) | ins;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    seen_low_d = seen_low_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = misalign_q;
    ce_d       = ce_q;
    we_d       = we_q;
    raddr_d    = raddr_q;
    rwdata_d   = rwdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          op_d    = op_t'(op_i);
          off_d   = addr_i[1:0];
          wdata_d = wdata_i[15:0];
          raddr_d = {addr_i[31:2], 2'b00};
          if (is_misaligned(op_t'(op_i), addr_i[1:0])) begin
            misalign_d = 1'b1;
            rdata_d    = '0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else if (op_t'(op_i) == OP_SW) begin
            misalign_d = 1'b0;
            ce_d       = 1'b1;
            we_d       = 1'b1;
            rwdata_d   = wdata_i;
            state_d    = S_WR;
          end else begin
            misalign_d = 1'b0;
            ce_d       = 1'b1;
            we_d       = 1'b0;
            state_d    = S_RD;
          end
        end
      end
      S_RD: state_d = S_RD_CAP;
      S_RD_CAP: begin
        if (is_load(op_q)) begin
          rdata_d = load_fmt(op_q, off_q, ram_data_i);
          ce_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rwdata_d = store_merge(op_q, off_q, wdata_q, ram_data_i);
          we_d     = 1'b1;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        // The write commits only on a high ack that follows an observed low ack.
        if (!ram_ack_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          seen_low_d = 1'b0;
          ce_d       = 1'b0;
          we_d       = 1'b0;
          rdata_d    = '0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LB;
      off_q      <= '0;
      wdata_q    <= '0;
      seen_low_q <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      raddr_q    <= '0;
      rwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      seen_low_q <= seen_low_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      raddr_q    <= raddr_d;
      rwdata_q   <= rwdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign misalign_o = misalign_q;
  assign ram_ce_o   = ce_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = raddr_q;
  assign ram_data_o = rwdata_q;
  assign stall_o    = req_i & ~done_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word RAM (read latency one edge, low-then-high write ack).
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        misalign_o;
  logic        stall_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_ack_i;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .op_i       (op_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .misalign_o (misalign_o),
    .stall_o    (stall_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i),
    .ram_ack_i  (ram_ack_i)
  );

  // RAM model
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = '0;
  logic        phase_q = 1'b0;
  int          wr_count = 0;
  logic        ce_seen = 1'b0;

  assign ram_data_i = rd_q;
  assign ram_ack_i  = !(ram_ce_o && ram_we_o && !phase_q);

  always @(posedge clk) begin
    if (ram_ce_o) ce_seen = 1'b1;
    if (ram_ce_o && !ram_we_o) rd_q <= mem[ram_addr_o[11:2]];
    if (ram_ce_o && ram_we_o) begin
      if (phase_q) begin
        mem[ram_addr_o[11:2]] = ram_data_o;
        wr_count = wr_count + 1;
      end
      phase_q <= !phase_q;
    end else begin
      phase_q <= 1'b0;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [31:0] res;
  logic        mis;
  int          stall_bad;
  logic        we_hist  [0:63];
  logic        ack_hist [0:63];

  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                         LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  // Starts in C0 (#1 after an edge); returns #1 after the edge ending the done cycle, req still high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int   cyc;
    logic got;
    req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
    lat = -1; stall_bad = 0; got = 1'b0; cyc = 0; res = '0; mis = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      we_hist[cyc]  = ram_we_o;
      ack_hist[cyc] = ram_ack_i;
      if (done_o) begin
        got = 1'b1; lat = cyc; res = rdata_o; mis = misalign_o;
        if (stall_o !== 1'b0) stall_bad++;
      end else if (stall_o !== 1'b1) begin
        stall_bad++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rdata_o, done_o, misalign_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h done=%b mis=%b ce=%b we=%b addr=%h data=%h, want all 0",
               rdata_o, done_o, misalign_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o);
    end
    req_i = 1'b1; #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_hi: got %b want 1", stall_o); end
    req_i = 1'b0; #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", stall_o); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [2:0]  ops  [5] = '{LW, LB, LBU, LHU, LH};
    logic [31:0] adrs [5] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h100};
    logic [31:0] exps [5] = '{32'h8899AABB, 32'hFFFFFF99, 32'h00000099, 32'h0000AABB, 32'hFFFF8899};
    mem[32'h100 >> 2] = 32'h8899AABB;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], adrs[i], 32'h0);
      req_i = 1'b0;
      checks++;
      if (res !== exps[i] || mis !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d_data: got %h mis=%b want %h mis=0", i, res, mis, exps[i]);
      end
      checks++;
      if (lat != 3 || stall_bad != 0) begin
        errors++;
        $display("FAIL load_%0d_timing: got done cycle %0d stall errs %0d want 3 and 0", i, lat, stall_bad);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sb();
    int w0;
    mem[32'h100 >> 2] = 32'h11223344;
    w0 = wr_count;
    run_op(SB, 32'h103, 32'h000000EE);
    req_i = 1'b0;
    checks++;
    if (lat != 5 || stall_bad != 0) begin
      errors++; $display("FAIL sb_timing: got done cycle %0d stall errs %0d want 5 and 0", lat, stall_bad);
    end
    checks++;
    if (we_hist[3] !== 1'b1 || ack_hist[3] !== 1'b0 || ack_hist[4] !== 1'b1) begin
      errors++;
      $display("FAIL sb_handshake: got we3=%b ack3=%b ack4=%b want 1 0 1", we_hist[3], ack_hist[3], ack_hist[4]);
    end
    checks++;
    if (mem[32'h100 >> 2] !== 32'h112233EE || wr_count - w0 != 1) begin
      errors++;
      $display("FAIL sb_ram: got %h writes %0d want 112233ee writes 1", mem[32'h100 >> 2], wr_count - w0);
    end
    @(posedge clk); #1;
    run_op(LW, 32'h100, 32'h0);
    req_i = 1'b0;
    checks++;
    if (res !== 32'h112233EE || lat != 3) begin
      errors++; $display("FAIL sb_readback: got %h at cycle %0d want 112233ee at 3", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    int w0;
    mem[32'h200 >> 2] = 32'h0;
    w0 = wr_count;
    run_op(SW, 32'h200, 32'hDEADBEEF);
    req_i = 1'b0;
    checks++;
    if (lat != 3 || stall_bad != 0) begin
      errors++; $display("FAIL sw_timing: got done cycle %0d stall errs %0d want 3 and 0", lat, stall_bad);
    end
    checks++;
    if (we_hist[1] !== 1'b1 || we_hist[2] !== 1'b1 || ack_hist[1] !== 1'b0 || ack_hist[2] !== 1'b1) begin
      errors++;
      $display("FAIL sw_handshake: got we1=%b we2=%b ack1=%b ack2=%b want 1 1 0 1",
               we_hist[1], we_hist[2], ack_hist[1], ack_hist[2]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem[32'h200 >> 2] !== 32'hDEADBEEF || wr_count - w0 != 1) begin
      errors++;
      $display("FAIL sw_ram: got %h writes %0d want deadbeef writes 1", mem[32'h200 >> 2], wr_count - w0);
    end
  endtask

  task automatic test_misalign();
    int w0;
    w0 = wr_count;
    ce_seen = 1'b0;
    run_op(LH, 32'h101, 32'h0);
    req_i = 1'b0;
    checks++;
    if (lat != 1 || mis !== 1'b1 || res !== 32'h0 || ce_seen !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lh: got cycle %0d mis=%b rdata=%h ce_seen=%b want 1 1 0 0", lat, mis, res, ce_seen);
    end
    @(posedge clk); #1;
    ce_seen = 1'b0;
    run_op(SW, 32'h202, 32'h55555555);
    req_i = 1'b0;
    checks++;
    if (lat != 1 || mis !== 1'b1 || ce_seen !== 1'b0) begin
      errors++;
      $display("FAIL misalign_sw: got cycle %0d mis=%b ce_seen=%b want 1 1 0", lat, mis, ce_seen);
    end
    checks++;
    if (mem[32'h200 >> 2] !== 32'hDEADBEEF || wr_count != w0) begin
      errors++;
      $display("FAIL misalign_ram: got %h writes %0d want deadbeef writes 0", mem[32'h200 >> 2], wr_count - w0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    mem[32'h240 >> 2] = 32'h0A0B0C0D;
    run_op(LW, 32'h240, 32'h0);
    checks++;
    if (res !== 32'h0A0B0C0D || lat != 3) begin
      errors++; $display("FAIL b2b_lw: got %h at cycle %0d want 0a0b0c0d at 3", res, lat);
    end
    run_op(LBU, 32'h243, 32'h0);
    checks++;
    if (res !== 32'h0000000D || lat != 3 || stall_bad != 0) begin
      errors++;
      $display("FAIL b2b_lbu: got %h at cycle %0d stall errs %0d want 0000000d at 3", res, lat, stall_bad);
    end
    run_op(SB, 32'h241, 32'h000000FF);
    req_i = 1'b0;
    checks++;
    if (lat != 5 || mem[32'h240 >> 2] !== 32'h0AFF0C0D) begin
      errors++;
      $display("FAIL b2b_sb: got cycle %0d word %h want 5 and 0aff0c0d", lat, mem[32'h240 >> 2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midwrite();
    int w0;
    mem[32'h300 >> 2] = 32'hCAFEBABE;
    w0 = wr_count;
    req_i = 1'b1; op_i = SH; addr_i = 32'h300; wdata_i = 32'h00001234;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b1 || ram_data_o !== 32'h1234BABE) begin
      errors++;
      $display("FAIL midwr_pre: got ce=%b we=%b data=%h want 1 1 1234babe", ram_ce_o, ram_we_o, ram_data_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rdata_o, done_o, misalign_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o} !== '0 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL midwr_reset: got ce=%b we=%b addr=%h data=%h done=%b stall=%b want zeros stall 1",
               ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, done_o, stall_o);
    end
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem[32'h300 >> 2] !== 32'hCAFEBABE || wr_count != w0) begin
      errors++;
      $display("FAIL midwr_ram: got %h writes %0d want cafebabe writes 0", mem[32'h300 >> 2], wr_count - w0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op(SH, 32'h302, 32'h00005678);
    req_i = 1'b0;
    checks++;
    if (lat != 5 || mem[32'h300 >> 2] !== 32'hCAFE5678) begin
      errors++;
      $display("FAIL midwr_after: got cycle %0d word %h want 5 and cafe5678", lat, mem[32'h300 >> 2]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst = 1'b0; req_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_sb();
    test_sw();
    test_misalign();
    test_back_to_back();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
